// File: rtl/izh_pkg.sv
// Shared constants, Q9.7 helpers and scheduler state encoding for the Izhikevich sweep engine.
package izh_pkg;

  localparam int Q_W  = 16;
  localparam int FRAC = 7;

  localparam logic signed [Q_W-1:0] V_C  = -16'sd8320;
  localparam logic signed [Q_W-1:0] U_R  = -16'sd1664;
  localparam int                    D_INC  = 1280;
  localparam int                    THR    = 3840;
  localparam int                    DV_OFS = 17920;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_EMIT   = 3'd4
  } state_t;

  function automatic logic signed [Q_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)       return 16'sh7fff;
    else if (x < -32'sd32768) return 16'sh8000;
    else                      return x[Q_W-1:0];
  endfunction

endpackage

// File: rtl/izh_update.sv
// Combinational Izhikevich neuron step: (V, U, I) -> (V', U', spike) in Q9.7.
module izh_update
  import izh_pkg::*;
(
  input  logic signed [Q_W-1:0] i_v,
  input  logic signed [Q_W-1:0] i_u,
  input  logic        [7:0]     i_i,
  output logic signed [Q_W-1:0] o_v,
  output logic signed [Q_W-1:0] o_u,
  output logic                  o_spike
);

  logic signed [31:0] w_v32;
  logic signed [31:0] w_u32;
  logic signed [31:0] w_i32;
  logic signed [31:0] w_vsq;
  logic signed [31:0] w_dv;
  logic signed [31:0] w_du;

  always_comb begin
    w_v32   = 32'(i_v);
    w_u32   = 32'(i_u);
    w_i32   = {24'd0, i_i};
    w_vsq   = w_v32 * w_v32;
    // All terms stay signed so every >>> floors toward minus infinity.
    w_dv    = (w_vsq >>> 12) + (w_v32 * 32'sd5) + 32'(DV_OFS) - w_u32 + (w_i32 <<< FRAC);
    w_du    = ((w_v32 >>> 2) - w_u32) >>> 10;
    o_spike = (w_v32 >= 32'(THR));
    if (o_spike) begin
      o_v = V_C;
      o_u = sat16(w_u32 + 32'(D_INC));
    end else begin
      o_v = sat16(w_v32 + (w_dv >>> 4));
      o_u = sat16(w_u32 + w_du);
    end
  end

endmodule

// File: rtl/izh_sweep_scheduler.sv
// Sweeps NUM_NEURONS virtual neurons through one izh_update unit per tick and streams spikes.
// Optional feature: define IZH_SPIKE_COUNT_EN for per-neuron saturating spike counters.
module izh_sweep_scheduler
  import izh_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int ID_W        = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  cur_we,
  input  logic [ID_W-1:0]       cur_addr,
  input  logic [7:0]            cur_data,
  input  logic [ID_W-1:0]       rd_addr,
  output logic signed [Q_W-1:0] rd_v,
  output logic signed [Q_W-1:0] rd_u,
  output logic [7:0]            rd_count,
  output logic                  spike_valid,
  output logic [ID_W-1:0]       spike_id,
  input  logic                  spike_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic [2:0]            dbg_state
);

  // Spike stream: an event is offered while spike_valid is high with spike_id stable;
  // it is consumed on the rising edge where spike_valid && spike_ready, and never withdrawn.

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_idx;
  logic signed [Q_W-1:0] r_v_mem [NUM_NEURONS];
  logic signed [Q_W-1:0] r_u_mem [NUM_NEURONS];
  logic [7:0]            r_i_mem [NUM_NEURONS];
  logic signed [Q_W-1:0] r_fv;
  logic signed [Q_W-1:0] r_fu;
  logic [7:0]            r_fi;
  logic signed [Q_W-1:0] r_nv;
  logic signed [Q_W-1:0] r_nu;
  logic                  r_spk;
  logic signed [Q_W-1:0] r_rd_v;
  logic signed [Q_W-1:0] r_rd_u;
  logic                  r_overrun;
  logic signed [Q_W-1:0] w_nv;
  logic signed [Q_W-1:0] w_nu;
  logic                  w_spk;
  logic                  w_last;
  logic                  w_advance;

  izh_update u_update (
    .i_v     (r_fv),
    .i_u     (r_fu),
    .i_i     (r_fi),
    .o_v     (w_nv),
    .o_u     (w_nu),
    .o_spike (w_spk)
  );

  assign w_last    = (r_idx == ID_W'(NUM_NEURONS - 1));
  assign w_advance = ((r_state == ST_WRITE) && !r_spk) ||
                     ((r_state == ST_EMIT) && spike_ready);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (tick) w_state_nxt = ST_FETCH;
      ST_FETCH:  w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = ST_WRITE;
      ST_WRITE:  if (r_spk)       w_state_nxt = ST_EMIT;
                 else if (w_last) w_state_nxt = ST_IDLE;
                 else             w_state_nxt = ST_FETCH;
      ST_EMIT:   if (spike_ready) w_state_nxt = w_last ? ST_IDLE : ST_FETCH;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != ST_IDLE);
    spike_valid = (r_state == ST_EMIT);
    spike_id    = r_idx;
    overrun     = r_overrun;
    rd_v        = r_rd_v;
    rd_u        = r_rd_u;
    dbg_state   = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        r_v_mem[k] <= V_C;
        r_u_mem[k] <= U_R;
        r_i_mem[k] <= '0;
      end
    end else begin
      if (cur_we) r_i_mem[cur_addr] <= cur_data;
      if (r_state == ST_WRITE) begin
        r_v_mem[r_idx] <= r_nv;
        r_u_mem[r_idx] <= r_nu;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_fv      <= '0;
      r_fu      <= '0;
      r_fi      <= '0;
      r_nv      <= '0;
      r_nu      <= '0;
      r_spk     <= 1'b0;
      r_rd_v    <= '0;
      r_rd_u    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_rd_v <= r_v_mem[rd_addr];
      r_rd_u <= r_u_mem[rd_addr];
      if (tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      if ((r_state == ST_IDLE) && tick) r_idx <= '0;
      else if (w_advance && !w_last)    r_idx <= r_idx + ID_W'(1);
      if (r_state == ST_FETCH) begin
        r_fv <= r_v_mem[r_idx];
        r_fu <= r_u_mem[r_idx];
        r_fi <= r_i_mem[r_idx];
      end
      if (r_state == ST_UPDATE) begin
        r_nv  <= w_nv;
        r_nu  <= w_nu;
        r_spk <= w_spk;
      end
    end
  end

`ifdef IZH_SPIKE_COUNT_EN
  logic [7:0] r_cnt_mem [NUM_NEURONS];
  logic [7:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) r_cnt_mem[k] <= '0;
      r_rd_count <= '0;
    end else begin
      if ((r_state == ST_WRITE) && r_spk && (r_cnt_mem[r_idx] != 8'hff))
        r_cnt_mem[r_idx] <= r_cnt_mem[r_idx] + 8'd1;
      r_rd_count <= r_cnt_mem[rd_addr];
    end
  end

  assign rd_count = r_rd_count;
`else
  assign rd_count = 8'd0;
`endif

endmodule
